// File: rtl/frame_packer_if.sv
// Pixel stream in, packed BRAM write port and status pulses out.
interface frame_packer_if #(
  parameter int unsigned IMG_WIDTH    = 240,
  parameter int unsigned IMG_HEIGHT   = 320,
  parameter int unsigned PIX_PER_WORD = 6
);
  localparam int unsigned FRAME_WORDS = IMG_HEIGHT * (IMG_WIDTH / PIX_PER_WORD);
  localparam int unsigned ADDR_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned DATA_W      = 8 * PIX_PER_WORD;

  logic              valid_in;
  logic [7:0]        pixel_in;
  logic              sof_in;
  logic [ADDR_W-1:0] bram_addr_out;
  logic [DATA_W-1:0] bram_din_out;
  logic              bram_we_out;
  logic              busy_out;
  logic              frame_done_out;
  logic              abort_out;

  // Pixel source / BRAM sink side.
  modport master (
    output valid_in, pixel_in, sof_in,
    input  bram_addr_out, bram_din_out, bram_we_out, busy_out, frame_done_out, abort_out
  );

  // Packer side.
  modport slave (
    input  valid_in, pixel_in, sof_in,
    output bram_addr_out, bram_din_out, bram_we_out, busy_out, frame_done_out, abort_out
  );
endinterface

// File: rtl/frame_packer.sv
// Packs a raster 8-bit pixel stream into PIX_PER_WORD-wide BRAM words,
// first pixel of each word in the MSBs, one linear address per word.
module frame_packer #(
  parameter int unsigned IMG_WIDTH    = 240,
  parameter int unsigned IMG_HEIGHT   = 320,
  parameter int unsigned PIX_PER_WORD = 6
) (
  input  logic          clk_in,
  input  logic          rst_in,
  frame_packer_if.slave bus
);
  localparam int unsigned WORDS_PER_ROW = IMG_WIDTH / PIX_PER_WORD;
  localparam int unsigned FRAME_WORDS   = IMG_HEIGHT * WORDS_PER_ROW;
  localparam int unsigned ADDR_W        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned DATA_W        = 8 * PIX_PER_WORD;
  localparam int unsigned SLOT_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned WORD_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned ROW_W         = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {IDLE, PACK} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic [DATA_W-1:0] pix_word_c;
  logic              last_pix_c;
  logic              start_c;

  // Next-state logic: frame start/restart, slot/word/row/address stepping, write strobe.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    word_d     = word_q;
    row_d      = row_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    addr_out_d = addr_out_q;
    din_d      = din_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    // Shifting left keeps the earliest pixel of the word in the MSBs once all slots fill.
    pix_word_c = DATA_W'(shift_q << 8) | DATA_W'(bus.pixel_in);
    last_pix_c = (row_q == ROW_LAST) && (word_q == WORD_LAST) && (slot_q == SLOT_LAST);
    // A sof on the final pixel of a frame belongs to that frame, not a restart.
    start_c    = bus.valid_in && bus.sof_in &&
                 ((state_q == IDLE) || ((state_q == PACK) && !last_pix_c));

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = PACK;
          slot_d  = SLOT_W'(1);
          word_d  = '0;
          row_d   = '0;
          addr_d  = '0;
          shift_d = pix_word_c;
        end
      end
      PACK: begin
        if (start_c) begin
          slot_d  = SLOT_W'(1);
          word_d  = '0;
          row_d   = '0;
          addr_d  = '0;
          shift_d = pix_word_c;
          abort_d = 1'b1;
        end else if (bus.valid_in) begin
          shift_d = pix_word_c;
          if (slot_q == SLOT_LAST) begin
            slot_d     = '0;
            we_d       = 1'b1;
            din_d      = pix_word_c;
            addr_out_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
            if (word_q == WORD_LAST) begin
              word_d = '0;
              row_d  = row_q + ROW_W'(1);
            end else begin
              word_d = word_q + WORD_W'(1);
            end
            if (last_pix_c) begin
              state_d = IDLE;
              done_d  = 1'b1;
              row_d   = '0;
              addr_d  = '0;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset drops any partial word silently.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      word_q     <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      addr_out_q <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      word_q     <= word_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      addr_out_q <= addr_out_d;
      din_q      <= din_d;
      we_q       <= we_d;
      busy_q     <= (state_d == PACK);
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.bram_addr_out  = addr_out_q;
  assign bus.bram_din_out   = din_q;
  assign bus.bram_we_out    = we_q;
  assign bus.busy_out       = busy_q;
  assign bus.frame_done_out = done_q;
  assign bus.abort_out      = abort_q;
endmodule

// File: tb/tb_frame_packer.sv
// Bench for frame_packer on a reduced 48x20 frame: pixel-index model checked
// every cycle, plus literal expectations on the write log.
module tb_frame_packer;
  localparam int IMG_WIDTH   = 48;
  localparam int IMG_HEIGHT  = 20;
  localparam int PPW         = 6;
  localparam int FRAME_PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int FRAME_WORDS = FRAME_PIX / PPW;
  localparam int ADDR_W      = $clog2(FRAME_WORDS);
  localparam int DATA_W      = 8 * PPW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  frame_packer_if #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .PIX_PER_WORD(PPW)) bus ();

  frame_packer #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .PIX_PER_WORD(PPW)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Observed write log and pulse counters.
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_din[$];
  int done_cnt, done_we_cnt, abort_cnt;

  // Model state: position of the next pixel within the frame.
  bit                m_in_frame = 1'b0;
  int                m_idx      = 0;
  logic [7:0]        m_pix[PPW];
  logic              m_we = 1'b0, m_done = 1'b0, m_abort = 1'b0, m_busy = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_din  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pack_model();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < PPW; k++) w[DATA_W-1-8*k -: 8] = m_pix[k];
    return w;
  endfunction

  // Word w of a frame whose pixel i carries (base+i) mod 256.
  function automatic logic [DATA_W-1:0] word_of(input int base, input int w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < PPW; k++) r[DATA_W-1-8*k -: 8] = 8'((base + PPW*w + k) % 256);
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_in_frame = 1'b0; m_idx = 0;
      m_we = 1'b0; m_done = 1'b0; m_abort = 1'b0; m_busy = 1'b0;
      m_addr = '0; m_din = '0;
    end else begin
      m_we = 1'b0; m_done = 1'b0; m_abort = 1'b0;
      if (bus.valid_in) begin
        if (bus.sof_in && !(m_in_frame && m_idx == FRAME_PIX - 1)) begin
          m_abort    = m_in_frame;
          m_in_frame = 1'b1;
          m_idx      = 0;
        end
        if (m_in_frame) begin
          m_pix[m_idx % PPW] = bus.pixel_in;
          if (m_idx % PPW == PPW - 1) begin
            m_we   = 1'b1;
            m_addr = ADDR_W'(m_idx / PPW);
            m_din  = pack_model();
          end
          m_idx++;
          if (m_idx == FRAME_PIX) begin
            m_done = 1'b1; m_in_frame = 1'b0; m_idx = 0;
          end
        end
      end
      m_busy = m_in_frame;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle comparison of every output against the model, plus logging.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("we",    64'(bus.bram_we_out),    64'(m_we));
      check("addr",  64'(bus.bram_addr_out),  64'(m_addr));
      check("din",   64'(bus.bram_din_out),   64'(m_din));
      check("busy",  64'(bus.busy_out),       64'(m_busy));
      check("done",  64'(bus.frame_done_out), 64'(m_done));
      check("abort", 64'(bus.abort_out),      64'(m_abort));
      if (bus.bram_we_out) begin
        log_addr.push_back(bus.bram_addr_out);
        log_din.push_back(bus.bram_din_out);
      end
      if (bus.frame_done_out) done_cnt++;
      if (bus.frame_done_out && bus.bram_we_out) done_we_cnt++;
      if (bus.abort_out) abort_cnt++;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    done_cnt = 0; done_we_cnt = 0; abort_cnt = 0;
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.pixel_in = p; bus.sof_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b0; bus.sof_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit sof_last);
    for (int i = 0; i < FRAME_PIX; i++) begin
      if (gaps)
        for (int g = 0; g < 4 && $urandom_range(0, 9) < 3; g++) idle(1);
      send(8'((base + i) % 256), (i == 0) || (sof_last && i == FRAME_PIX - 1));
    end
  endtask

  task automatic check_seq(input string name, input int start, input int base);
    int bad = 0;
    if (log_addr.size() < start + FRAME_WORDS) bad = FRAME_WORDS;
    else
      for (int i = 0; i < FRAME_WORDS; i++)
        if (log_addr[start+i] !== ADDR_W'(i) || log_din[start+i] !== word_of(base, i)) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.pixel_in = '0; bus.sof_in = 1'b0;
    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    idle(3);
    check("rst_we",   64'(bus.bram_we_out),   64'd0);
    check("rst_addr", 64'(bus.bram_addr_out), 64'd0);
    check("rst_din",  64'(bus.bram_din_out),  64'd0);
    check("rst_busy", 64'(bus.busy_out),      64'd0);
    rst = 1'b0;
    idle(2);

    // Continuous full frame.
    clear_log();
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check("a_count",   64'(log_addr.size()), 64'(FRAME_WORDS));
    check("a_addr0",   64'(log_addr[0]), 64'd0);
    check("a_din0",    64'(log_din[0]),  64'h000102030405);
    check("a_din1",    64'(log_din[1]),  64'h060708090A0B);
    check("a_lastadr", 64'(log_addr[FRAME_WORDS-1]), 64'(FRAME_WORDS - 1));
    check("a_done",    64'(done_cnt),    64'd1);
    check("a_done_we", 64'(done_we_cnt), 64'd1);
    check_seq("a_seq", 0, 0);

    // Same frame with random valid gaps.
    clear_log();
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    check("b_count", 64'(log_addr.size()), 64'(FRAME_WORDS));
    check("b_done",  64'(done_cnt), 64'd1);
    check_seq("b_seq", 0, 0);

    // Pixels without sof in IDLE are dropped.
    clear_log();
    for (int i = 0; i < 50; i++) send(8'(i), 1'b0);
    idle(2);
    check("c_nowrite", 64'(log_addr.size()), 64'd0);
    check("c_busy",    64'(bus.busy_out),    64'd0);
    send_frame(16, 1'b0, 1'b0);
    idle(3);
    check("c_addr0", 64'(log_addr[0]), 64'd0);
    check("c_din0",  64'(log_din[0]),  64'h101112131415);
    check_seq("c_seq", 0, 16);

    // Restart after 100 pixels.
    clear_log();
    for (int i = 0; i < 100; i++) send(8'(i), i == 0);
    send_frame(160, 1'b0, 1'b0);
    idle(3);
    check("d_count",  64'(log_addr.size()), 64'(16 + FRAME_WORDS));
    check("d_din15",  64'(log_din[15]),  64'h5A5B5C5D5E5F);
    check("d_abort",  64'(abort_cnt),    64'd1);
    check("d_addr16", 64'(log_addr[16]), 64'd0);
    check("d_din16",  64'(log_din[16]),  64'hA0A1A2A3A4A5);
    check("d_done",   64'(done_cnt),     64'd1);
    check_seq("d_seq", 16, 160);

    // Asynchronous reset after 3 pixels of word 5.
    clear_log();
    for (int i = 0; i < 33; i++) send(8'(i), i == 0);
    @(posedge clk);
    #2;
    bus.valid_in = 1'b0; bus.sof_in = 1'b0;
    rst = 1'b1;
    #1;
    check("e_we",    64'(bus.bram_we_out),    64'd0);
    check("e_addr",  64'(bus.bram_addr_out),  64'd0);
    check("e_din",   64'(bus.bram_din_out),   64'd0);
    check("e_busy",  64'(bus.busy_out),       64'd0);
    check("e_done",  64'(bus.frame_done_out), 64'd0);
    check("e_abort", 64'(bus.abort_out),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("e_count", 64'(log_addr.size()), 64'd5);
    send_frame(64, 1'b0, 1'b0);
    idle(3);
    check("e_addr5", 64'(log_addr[5]), 64'd0);
    check("e_din5",  64'(log_din[5]),  64'h404142434445);
    check("e_noab",  64'(abort_cnt),   64'd0);

    // sof coinciding with a frame's last pixel is not a restart.
    clear_log();
    send_frame(0, 1'b0, 1'b1);
    idle(3);
    check("g_count", 64'(log_addr.size()), 64'(FRAME_WORDS));
    check("g_abort", 64'(abort_cnt), 64'd0);
    check("g_done",  64'(done_cnt),  64'd1);

    // Back-to-back frames with no dead cycle.
    clear_log();
    send_frame(0, 1'b0, 1'b0);
    send_frame(85, 1'b0, 1'b0);
    idle(3);
    check("f_count",   64'(log_addr.size()), 64'(2 * FRAME_WORDS));
    check("f_done",    64'(done_cnt),    64'd2);
    check("f_done_we", 64'(done_we_cnt), 64'd2);
    check("f_abort",   64'(abort_cnt),   64'd0);
    check_seq("f_seq0", 0, 0);
    check_seq("f_seq1", FRAME_WORDS, 85);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
